// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment/extension and register-file writeback drive.
// Optional retired-instruction counter enabled by defining MEM_WB_INSTRET_EN.
module mem_wb_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  logic         in_reg_write,
    input  logic [4:0]   in_rd,
    input  logic [1:0]   in_wb_sel,
    input  logic [2:0]   in_funct3,
    input  logic [N-1:0] in_alu_result,
    input  logic [N-1:0] in_mem_rdata,
    input  logic [N-1:0] in_pc_plus4,
    input  logic [N-1:0] in_imm,
    output logic         rf_write_en,
    output logic [4:0]   rf_wr,
    output logic [N-1:0] rf_wd,
    output logic         wb_valid,
`ifdef MEM_WB_INSTRET_EN
    output logic [63:0]  instret,
`endif
    output logic         wb_misalign
);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    logic         valid_q;
    logic         reg_write_q;
    logic [4:0]   rd_q;
    logic [1:0]   wb_sel_q;
    logic [2:0]   funct3_q;
    logic [N-1:0] alu_q;
    logic [N-1:0] rdata_q;
    logic [N-1:0] pc4_q;
    logic [N-1:0] imm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_sel_q    <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
        end else if (!stall) begin
            valid_q     <= in_valid;
            reg_write_q <= in_reg_write;
            rd_q        <= in_rd;
            wb_sel_q    <= in_wb_sel;
            funct3_q    <= in_funct3;
            alu_q       <= in_alu_result;
            rdata_q     <= in_mem_rdata;
            pc4_q       <= in_pc_plus4;
            imm_q       <= in_imm;
        end
    end

    logic [1:0]   off;
    logic [7:0]   byte_v;
    logic [15:0]  half_v;
    logic [N-1:0] load_val;
    logic         misalign;

    assign off = alu_q[1:0];

    always_comb begin
        byte_v = rdata_q[7:0];
        case (off)
            2'd1:    byte_v = rdata_q[15:8];
            2'd2:    byte_v = rdata_q[23:16];
            2'd3:    byte_v = rdata_q[31:24];
            default: byte_v = rdata_q[7:0];
        endcase
        half_v = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    end

    // Illegal funct3 encodings fall into the misalign path and yield zero data.
    always_comb begin
        load_val = '0;
        misalign = 1'b0;
        case (funct3_q)
            3'b000: load_val = {{(N-8){byte_v[7]}}, byte_v};
            3'b001: begin
                load_val = {{(N-16){half_v[15]}}, half_v};
                misalign = off[0];
            end
            3'b010: begin
                load_val = rdata_q;
                misalign = (off != 2'd0);
            end
            3'b100: load_val = {{(N-8){1'b0}}, byte_v};
            3'b101: begin
                load_val = {{(N-16){1'b0}}, half_v};
                misalign = off[0];
            end
            default: misalign = 1'b1;
        endcase
    end

    assign wb_misalign = valid_q & (wb_sel_q == WB_LOAD) & misalign;

    always_comb begin
        case (wb_sel_q)
            WB_ALU:  rf_wd = alu_q;
            WB_LOAD: rf_wd = wb_misalign ? '0 : load_val;
            WB_PC4:  rf_wd = pc4_q;
            default: rf_wd = imm_q;
        endcase
    end

    assign rf_write_en = valid_q & reg_write_q & (rd_q != 5'd0) & ~wb_misalign;
    assign rf_wr       = rd_q;
    assign wb_valid    = valid_q;

`ifdef MEM_WB_INSTRET_EN
    logic [63:0] instret_q;

    // The held instruction retires whenever it leaves the stage, by advance or by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (valid_q && (flush || !stall)) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule
